// File: rtl/wb_packer.sv
// Packs ReLU result lanes to saturated 4-bit nibbles and queues them for ordered
// writes into the even/odd activation banks, signalling when a layer has fully drained.
module wb_packer #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int AW = 10,
  parameter int D  = 4
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              i_wr,
  input  logic              i_ev_odd_n,
  input  logic [AW-1:0]     i_even_addr,
  input  logic [AW-1:0]     i_odd_addr,
  input  logic [N*W-1:0]    i_data,
  input  logic              i_last,
  output logic              o_mem_even_we,
  output logic              o_mem_odd_we,
  output logic [AW-1:0]     o_mem_even_addr,
  output logic [AW-1:0]     o_mem_odd_addr,
  output logic [4*W-1:0]    o_mem_even_data,
  output logic [4*W-1:0]    o_mem_odd_data,
  input  logic              i_mem_even_gnt,
  input  logic              i_mem_odd_gnt,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_ovf,
  output logic              o_done
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;

  logic              bank_q [D];
  logic              bank_d [D];
  logic [AW-1:0]     addr_q [D];
  logic [AW-1:0]     addr_d [D];
  logic [4*W-1:0]    data_q [D];
  logic [4*W-1:0]    data_d [D];

  logic [4*W-1:0]    packed_word;
  logic              head_valid;
  logic              head_bank;
  logic [AW-1:0]     head_addr;
  logic [4*W-1:0]    head_data;
  logic              pop;
  logic              push;

  // Each lane is unsigned; anything above 15 clamps to 15.
  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    logic [N-1:0] lane;
    assign lane = i_data[N*W-1-gi*N -: N];
    assign packed_word[4*W-1-gi*4 -: 4] = (lane > N'(15)) ? 4'hF : lane[3:0];
  end

  // Gating with rst keeps a pending head from being written during the reset cycle.
  assign head_valid = !empty_q && !rst;
  assign head_bank  = bank_q[rd_ptr_q];
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];

  assign o_mem_even_we   = head_valid && head_bank;
  assign o_mem_odd_we    = head_valid && !head_bank;
  assign o_mem_even_addr = (head_valid && head_bank)  ? head_addr : '0;
  assign o_mem_odd_addr  = (head_valid && !head_bank) ? head_addr : '0;
  assign o_mem_even_data = (head_valid && head_bank)  ? head_data : '0;
  assign o_mem_odd_data  = (head_valid && !head_bank) ? head_data : '0;

  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_ovf   = ovf_q;
  assign o_done  = (state_q == DONE);

  always_comb begin
    pop      = head_valid && (head_bank ? i_mem_even_gnt : i_mem_odd_gnt);
    push     = i_wr && (!full_q || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      bank_d[wr_ptr_q] = i_ev_odd_n;
      addr_d[wr_ptr_q] = i_ev_odd_n ? i_even_addr : i_odd_addr;
      data_d[wr_ptr_q] = packed_word;
      wr_ptr_d = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(D));
    empty_d = (count_d == '0);
    // A word arriving while full with no head leaving is lost.
    ovf_d   = ovf_q || (i_wr && full_q && !pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_last)    state_d = DRAIN;
        else if (i_wr) state_d = ACTIVE;
      end
      ACTIVE: if (i_last) state_d = DRAIN;
      DRAIN:  if (count_d == '0) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only observed through the occupancy flags.
  always_ff @(posedge ck) begin
    bank_q <= bank_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_wb_packer.sv
// Directed and randomized checks of wb_packer against a queue-based reference model
// that tracks entries, overflow and layer completion at transaction level.
module tb_wb_packer;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 10;
  localparam int D  = 4;

  logic              ck;
  logic              rst;
  logic              i_wr;
  logic              i_ev_odd_n;
  logic [AW-1:0]     i_even_addr;
  logic [AW-1:0]     i_odd_addr;
  logic [N*W-1:0]    i_data;
  logic              i_last;
  logic              o_mem_even_we;
  logic              o_mem_odd_we;
  logic [AW-1:0]     o_mem_even_addr;
  logic [AW-1:0]     o_mem_odd_addr;
  logic [4*W-1:0]    o_mem_even_data;
  logic [4*W-1:0]    o_mem_odd_data;
  logic              i_mem_even_gnt;
  logic              i_mem_odd_gnt;
  logic              o_full;
  logic              o_empty;
  logic              o_ovf;
  logic              o_done;

  wb_packer #(.N(N), .W(W), .AW(AW), .D(D)) dut (
    .ck              (ck),
    .rst             (rst),
    .i_wr            (i_wr),
    .i_ev_odd_n      (i_ev_odd_n),
    .i_even_addr     (i_even_addr),
    .i_odd_addr      (i_odd_addr),
    .i_data          (i_data),
    .i_last          (i_last),
    .o_mem_even_we   (o_mem_even_we),
    .o_mem_odd_we    (o_mem_odd_we),
    .o_mem_even_addr (o_mem_even_addr),
    .o_mem_odd_addr  (o_mem_odd_addr),
    .o_mem_even_data (o_mem_even_data),
    .o_mem_odd_data  (o_mem_odd_data),
    .i_mem_even_gnt  (i_mem_even_gnt),
    .i_mem_odd_gnt   (i_mem_odd_gnt),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_ovf           (o_ovf),
    .o_done          (o_done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    bit              bank;
    logic [AW-1:0]   addr;
    logic [4*W-1:0]  data;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  bit   m_drain;
  bit   m_done;
  int   tests;
  int   fails;
  int   done_seen;
  int   writes_seen;

  function automatic logic [4*W-1:0] pack(logic [N*W-1:0] d);
    logic [4*W-1:0] r;
    int unsigned    v;
    r = '0;
    for (int i = 0; i < W; i++) begin
      v = int'((d >> (N * (W - 1 - i))) & 64'hFF);
      if (v > 15) v = 15;
      r = r | ((4*W)'(v) << (4 * (W - 1 - i)));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs with the model, then advance the model across the edge.
  task automatic cyc();
    ent_t h;
    bit   hv, pop, push, lost;
    #1;
    hv = (q.size() > 0) && !rst;
    if (q.size() > 0) h = q[0];
    chk("even_we",   o_mem_even_we,   hv && h.bank);
    chk("odd_we",    o_mem_odd_we,    hv && !h.bank);
    chk("even_addr", o_mem_even_addr, (hv && h.bank)  ? h.addr : '0);
    chk("odd_addr",  o_mem_odd_addr,  (hv && !h.bank) ? h.addr : '0);
    chk("even_data", o_mem_even_data, (hv && h.bank)  ? h.data : '0);
    chk("odd_data",  o_mem_odd_data,  (hv && !h.bank) ? h.data : '0);
    chk("full",      o_full,  q.size() == D);
    chk("empty",     o_empty, q.size() == 0);
    chk("ovf",       o_ovf,   m_ovf);
    chk("done",      o_done,  m_done);
    if (o_done) done_seen++;
    pop  = hv && (h.bank ? i_mem_even_gnt : i_mem_odd_gnt);
    push = i_wr && ((q.size() < D) || pop);
    lost = i_wr && (q.size() == D) && !pop;
    @(posedge ck);
    if (rst) begin
      q.delete();
      m_ovf   = 0;
      m_drain = 0;
      m_done  = 0;
    end else begin
      if (pop) begin
        writes_seen++;
        $display("[TB] t=%0t write %s addr=%0d data=%08h", $time, h.bank ? "even" : "odd", h.addr, h.data);
        void'(q.pop_front());
      end
      if (push) begin
        ent_t e;
        e.bank = i_ev_odd_n;
        e.addr = i_ev_odd_n ? i_even_addr : i_odd_addr;
        e.data = pack(i_data);
        q.push_back(e);
      end
      if (lost) begin
        m_ovf = 1;
        $display("[TB] t=%0t word dropped while full", $time);
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_drain) begin
        if (q.size() == 0) begin
          m_done  = 1;
          m_drain = 0;
        end
      end else if (i_last) begin
        m_drain = 1;
      end
    end
    @(negedge ck);
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < W; i++) begin
      d = (d << N) | ((N*W)'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(12, 18)));
    end
    return d;
  endfunction

  int done_before;
  int writes_before;

  initial begin
    tests = 0; fails = 0; done_seen = 0; writes_seen = 0;
    m_ovf = 0; m_drain = 0; m_done = 0;
    rst = 1; i_wr = 0; i_ev_odd_n = 0; i_even_addr = '0; i_odd_addr = '0;
    i_data = '0; i_last = 0; i_mem_even_gnt = 0; i_mem_odd_gnt = 0;
    @(posedge ck);
    @(negedge ck);
    cyc();
    rst = 0;
    cyc();

    // Single word with mixed saturating lanes
    i_mem_even_gnt = 1; i_mem_odd_gnt = 1;
    i_wr = 1; i_ev_odd_n = 1; i_even_addr = 10'd5; i_odd_addr = 10'd9;
    i_data = 64'h031F000F1001FF07;
    cyc();
    i_wr = 0;
    #1;
    chk("single_we",   o_mem_even_we,   1'b1);
    chk("single_addr", o_mem_even_addr, 10'd5);
    chk("single_data", o_mem_even_data, 32'h3F0FF1F7);
    chk("single_odd",  o_mem_odd_we,    1'b0);
    cyc();
    cyc();

    // Back-pressure: five pushes into a depth-4 FIFO with no grant
    i_mem_even_gnt = 0; i_mem_odd_gnt = 0;
    writes_before = writes_seen;
    for (int i = 0; i < 5; i++) begin
      i_wr = 1; i_ev_odd_n = 1; i_even_addr = AW'(20 + i); i_data = rand_data();
      cyc();
      if (i == 3) begin
        #1;
        chk("bp_full_after_4", o_full, 1'b1);
      end
    end
    i_wr = 0;
    #1;
    chk("bp_ovf", o_ovf, 1'b1);
    i_mem_even_gnt = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk("bp_write_count", 64'(writes_seen - writes_before), 64'd4);

    // Alternating banks with both grants high
    i_mem_odd_gnt = 1;
    writes_before = writes_seen;
    for (int i = 0; i < 4; i++) begin
      i_wr = 1; i_ev_odd_n = (i % 2 == 0); i_even_addr = AW'(100 + i);
      i_odd_addr = AW'(200 + i); i_data = rand_data();
      cyc();
    end
    i_wr = 0;
    cyc();
    cyc();
    chk("alt_write_count", 64'(writes_seen - writes_before), 64'd4);

    // Drain: three pushes, then i_last, even grant toggling
    done_before = done_seen;
    for (int i = 0; i < 3; i++) begin
      i_mem_even_gnt = (i % 2 == 0);
      i_wr = 1; i_ev_odd_n = 1; i_even_addr = AW'(300 + i); i_data = rand_data();
      cyc();
    end
    i_wr = 0; i_last = 1; i_mem_even_gnt = 1;
    cyc();
    i_last = 0;
    for (int i = 0; i < 10; i++) begin
      i_mem_even_gnt = (i % 2 == 1);
      cyc();
    end
    chk("drain_done_pulses", 64'(done_seen - done_before), 64'd1);
    chk("drain_empty", o_empty, 1'b1);

    // Reset with two entries pending
    i_mem_even_gnt = 0; i_mem_odd_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      i_wr = 1; i_ev_odd_n = (i == 0); i_even_addr = AW'(400 + i);
      i_odd_addr = AW'(500 + i); i_data = rand_data();
      cyc();
    end
    i_wr = 0; i_last = 1;
    cyc();
    i_last = 0; rst = 1; i_mem_even_gnt = 1; i_mem_odd_gnt = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_no_even_we", o_mem_even_we, 1'b0);
      chk("rst_no_odd_we",  o_mem_odd_we,  1'b0);
      chk("rst_done",       o_done,        1'b0);
      chk("rst_ovf",        o_ovf,         1'b0);
      chk("rst_empty",      o_empty,       1'b1);
      cyc();
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      i_wr           = ($urandom_range(0, 1) == 1);
      i_ev_odd_n     = ($urandom_range(0, 1) == 1);
      i_even_addr    = AW'($urandom);
      i_odd_addr     = AW'($urandom);
      i_data         = rand_data();
      i_last         = ($urandom_range(0, 15) == 0);
      i_mem_even_gnt = ($urandom_range(0, 9) < 6);
      i_mem_odd_gnt  = ($urandom_range(0, 9) < 6);
      cyc();
    end
    rst = 0; i_wr = 0; i_last = 0; i_mem_even_gnt = 1; i_mem_odd_gnt = 1;
    for (int i = 0; i < D + 2; i++) cyc();
    chk("final_empty", o_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_packer.md
WB_PACKER -- requirements
Module: wb_packer

Interface
REQ-001 Param N, default 8, datapath activation lane width in bits; N SHALL be at least 4.
REQ-002 Param W, default 8, number of lanes per word.
REQ-003 Param AW, default 10, bank address width.
REQ-004 Param D, default 4, FIFO depth, a power of 2.
REQ-005 ck  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 i_wr  in  1  result word valid from the datapath ReLU stage.
REQ-008 i_ev_odd_n  in  1  target bank select: 1 = even bank, 0 = odd bank.
REQ-009 i_even_addr, i_odd_addr  in  AW each  write address for each bank; only the selected one is used.
REQ-010 i_data  in  N*W  ReLU result lanes; lane 0 at bits [N*W-1 -: N].
REQ-011 i_last  in  1  layer-complete indication from the control fsm (pulse).
REQ-012 o_mem_even_we, o_mem_odd_we  out  1 each  bank write request.
REQ-013 o_mem_even_addr, o_mem_odd_addr  out  AW each  bank write address.
REQ-014 o_mem_even_data, o_mem_odd_data  out  4*W each  packed word; lane 0 at bits [4*W-1 -: 4].
REQ-015 i_mem_even_gnt, i_mem_odd_gnt  in  1 each  bank accepts the write this cycle.
REQ-016 o_full, o_empty  out  1 each  FIFO status.
REQ-017 o_ovf  out  1  sticky overflow flag.
REQ-018 o_done  out  1  one-cycle pulse when all words of the layer have been written.

Function
REQ-019 Packing: each N-bit lane SHALL be treated as unsigned and saturated to 4 bits (value > 15 becomes 15, otherwise the low 4 bits are kept); lane order SHALL be preserved.
REQ-020 Push: on an edge with i_wr=1 and the FIFO not full, {bank, selected address, packed word} SHALL be stored at the tail.
REQ-021 Head presentation: the head entry SHALL drive only its bank's we/addr/data; the other bank's we SHALL be 0 and its addr/data SHALL hold 0.
REQ-022 Latency: a word pushed into an empty FIFO at edge t SHALL appear as we=1 in the cycle following t.
REQ-023 Pop: the head SHALL be popped on an edge where the asserted we and the matching gnt are both 1; the non-matching gnt SHALL be ignored.
REQ-024 Write order: at most one bank write SHALL be issued per cycle, in strict push order.
REQ-025 Head hold: while gnt is low, we, addr and data SHALL hold stable.
REQ-026 Full push: when full, i_wr with a same-edge pop SHALL be accepted; i_wr without a pop SHALL drop the word and set o_ovf.
REQ-027 Overflow clear: o_ovf SHALL stay set until rst.
REQ-028 Status flags: o_full SHALL be 1 iff the FIFO holds D entries; o_empty SHALL be 1 iff it holds 0 entries; both SHALL be registered.
REQ-029 FSM states: IDLE, ACTIVE, DRAIN, DONE.
REQ-030 IDLE to ACTIVE on i_wr; ACTIVE to DRAIN on i_last; IDLE to DRAIN on i_last.
REQ-031 DRAIN to DONE on the edge where the FIFO becomes (or already is) empty with no push; DONE to IDLE after one cycle.
REQ-032 o_done SHALL be 1 only in DONE.
REQ-033 i_wr in DRAIN SHALL still be accepted and SHALL delay DONE until it is written.
REQ-034 i_last in DRAIN or DONE SHALL be ignored.
REQ-035 Same-edge i_wr and i_last SHALL push the word first; DONE SHALL follow only after that word is written.

Reset
REQ-036 On rst=1 at an edge: FIFO emptied, state set to IDLE, o_ovf cleared.
REQ-037 Reset values: we=0, addr=0, data=0 on both banks; o_empty=1, o_full=0, o_done=0.
REQ-038 Reset mid-operation SHALL discard pending entries without issuing a write in the reset cycle or the cycle after it.

Verification
REQ-039 Single word: i_data lanes {0x03,0x1F,0x00,0x0F,0x10,0x01,0xFF,0x07}, i_ev_odd_n=1, i_even_addr=5, gnt tied 1 -> next cycle o_mem_even_we=1, addr=5, data=0x3F0FF1F7, odd we=0.
REQ-040 Back-pressure: 5 consecutive pushes with D=4 and gnt=0 -> o_full=1 after the 4th push; 5th word dropped; o_ovf=1; raising gnt -> exactly 4 writes in push order.
REQ-041 Alternating banks: 4 pushes alternating even/odd, both gnt tied 1 -> 4 writes on consecutive cycles, one bank per cycle, correct addresses.
REQ-042 Drain: 3 pushes, then i_last, even gnt toggling 1/0 -> o_done pulses once, exactly one cycle after the 3rd write; o_empty=1.
REQ-043 Reset mid-drain: rst asserted with 2 pending entries -> no we in the following 2 cycles; o_done, o_ovf=0; o_empty=1.
